// File: rtl/tick_interval_meter.sv
// rtl/tick_interval_meter.sv - counts timer ticks between a start and a stop event
//
// Purpose:
//   Single-shot interval meter. arm_i enables it, start_i begins counting
//   timer_tick_i pulses, and stop_i (or reaching limit_i) captures the count
//   into count_o with a one-cycle valid_o strobe. The captured count can be
//   used directly as the load value of a countdown timer.
//
// Ports:
//   clk_i          system clock, rising edge
//   rstn_i         asynchronous active-low reset
//   arm_i          pulse: enable capture of the next start event
//   abort_i        pulse: return to idle without a result (highest priority)
//   start_i        start event, level sampled
//   stop_i         stop event, level sampled
//   timer_tick_i   tick enable, counted only when high
//   limit_i        timeout in ticks, 0 disables the timeout
//   count_o        captured tick count, held until the next result
//   valid_o        one-cycle pulse when count_o is updated
//   timeout_o      1 = last result ended by limit, 0 = ended by stop
//   busy_o         high while armed or counting
//   running_o      high while counting

module tick_interval_meter #(
    parameter int CW = 32
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          arm_i,
    input  logic          abort_i,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic          timer_tick_i,
    input  logic [CW-1:0] limit_i,
    output logic [CW-1:0] count_o,
    output logic          valid_o,
    output logic          timeout_o,
    output logic          busy_o,
    output logic          running_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ARMED    = 2'd1,
        S_COUNTING = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_count;
    logic          r_valid;
    logic          r_timeout;
    logic          r_busy;
    logic          r_running;

    // One extra bit so the limit compare never sees a wrapped value.
    logic [CW:0]   w_cnt_plus1;
    logic [CW-1:0] w_cnt_inc;
    logic          w_limit_hit;
    logic          w_result;

    assign w_cnt_plus1 = {1'b0, r_cnt} + {{CW{1'b0}}, 1'b1};

    // Saturating increment: all-ones is sticky.
    assign w_cnt_inc = (timer_tick_i && !(&r_cnt)) ? w_cnt_plus1[CW-1:0] : r_cnt;

    // Compare with >= rather than == so that lowering limit_i below the
    // running count still fires the timeout on the next tick.
    assign w_limit_hit = timer_tick_i && (limit_i != '0)
                         && (w_cnt_plus1 >= {1'b0, limit_i});

    assign w_result = (r_state == S_COUNTING) && !abort_i
                      && (stop_i || w_limit_hit);

    always_comb begin
        w_state_nx = r_state;
        if (abort_i) begin
            w_state_nx = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:     if (arm_i)   w_state_nx = S_ARMED;
                S_ARMED:    if (start_i) w_state_nx = S_COUNTING;
                S_COUNTING: if (stop_i || w_limit_hit) w_state_nx = S_IDLE;
                default:    w_state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_count   <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_busy    <= (w_state_nx != S_IDLE);
            r_running <= (w_state_nx == S_COUNTING);
            r_valid   <= w_result;

            if (!abort_i) begin
                if (r_state == S_ARMED && start_i) begin
                    // A tick coincident with start is deliberately dropped.
                    r_cnt <= '0;
                end else if (r_state == S_COUNTING) begin
                    r_cnt <= w_cnt_inc;
                    if (stop_i) begin
                        // Stop beats a simultaneous timeout, but the reported
                        // value is clamped to the limit in that case.
                        r_count   <= w_limit_hit ? limit_i : w_cnt_inc;
                        r_timeout <= 1'b0;
                    end else if (w_limit_hit) begin
                        r_count   <= limit_i;
                        r_timeout <= 1'b1;
                    end
                end
            end
        end
    end

    assign count_o   = r_count;
    assign valid_o   = r_valid;
    assign timeout_o = r_timeout;
    assign busy_o    = r_busy;
    assign running_o = r_running;

endmodule

// File: tb/tb_tick_interval_meter.sv
// tb/tb_tick_interval_meter.sv - self-checking bench for tick_interval_meter

module tb_tick_interval_meter;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        arm_i, abort_i, start_i, stop_i, tick_i;
    logic [31:0] limit_i;
    logic [31:0] count_o;
    logic        valid_o, timeout_o, busy_o, running_o;
    logic [3:0]  count4_o;
    logic        valid4_o, timeout4_o, busy4_o, running4_o;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    tick_interval_meter #(.CW(32)) dut (
        .clk_i(clk), .rstn_i(rstn_i), .arm_i(arm_i), .abort_i(abort_i),
        .start_i(start_i), .stop_i(stop_i), .timer_tick_i(tick_i),
        .limit_i(limit_i), .count_o(count_o), .valid_o(valid_o),
        .timeout_o(timeout_o), .busy_o(busy_o), .running_o(running_o)
    );

    tick_interval_meter #(.CW(4)) dut4 (
        .clk_i(clk), .rstn_i(rstn_i), .arm_i(arm_i), .abort_i(abort_i),
        .start_i(start_i), .stop_i(stop_i), .timer_tick_i(tick_i),
        .limit_i(limit_i[3:0]), .count_o(count4_o), .valid_o(valid4_o),
        .timeout_o(timeout4_o), .busy_o(busy4_o), .running_o(running4_o)
    );

    typedef struct {
        logic        arm, abort, start, stop, tick;
        logic [31:0] limit;
        logic        v, t, b, r;
        logic [31:0] c;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic a, logic ab, logic s, logic st, logic t,
                                logic [31:0] lim, logic v, logic to, logic b,
                                logic r, logic [31:0] c);
        vec_t x;
        x.arm = a; x.abort = ab; x.start = s; x.stop = st; x.tick = t;
        x.limit = lim; x.v = v; x.t = to; x.b = b; x.r = r; x.c = c;
        return x;
    endfunction

    // Compared vectors are {valid, timeout, busy, running, count}.
    task automatic chk(string name, logic [35:0] act, logic [35:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got v%b t%b b%b r%b c%0d, expected v%b t%b b%b r%b c%0d",
                      name, act[35], act[34], act[33], act[32], act[31:0],
                      exp[35], exp[34], exp[33], exp[32], exp[31:0]);
    endtask

    task automatic drive(logic a, logic ab, logic s, logic st, logic t, logic [31:0] lim);
        arm_i = a; abort_i = ab; start_i = s; stop_i = st; tick_i = t; limit_i = lim;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [35:0] outs();
        return {valid_o, timeout_o, busy_o, running_o, count_o};
    endfunction

    // Reference model: interval measurement expressed as plain arithmetic.
    int     m_mode;      // 0 idle, 1 waiting for start, 2 measuring
    longint m_ticks;
    longint m_count;
    bit     m_valid, m_to;
    localparam longint MAXV = 64'd4294967295;

    task automatic model_reset();
        m_mode = 0; m_ticks = 0; m_count = 0; m_valid = 0; m_to = 0;
    endtask

    task automatic model_step(bit a, bit ab, bit s, bit st, bit t, longint lim);
        longint after;
        bit     hit;
        m_valid = 0;
        if (ab) m_mode = 0;
        else if (m_mode == 0) begin
            if (a) m_mode = 1;
        end else if (m_mode == 1) begin
            if (s) begin m_mode = 2; m_ticks = 0; end
        end else begin
            after = t ? ((m_ticks + 1 > MAXV) ? MAXV : m_ticks + 1) : m_ticks;
            hit   = t && lim != 0 && (m_ticks + 1 >= lim);
            if (st || hit) begin
                m_count = hit ? lim : after;
                m_to    = hit && !st;
                m_valid = 1;
                m_mode  = 0;
            end
            m_ticks = after;
        end
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        rstn_i = 1'b0;
        repeat (2) cycle();
        rstn_i = 1'b1;
        model_reset();
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        rstn_i = 1'b0;
        repeat (2) cycle();
        chk("reset_state", outs(), 36'd0);
        rstn_i = 1'b1;
        cycle();

        // Basic measurement: 5 ticks, stop without tick.
        tbl.push_back(mk(1,0,0,0,0, 0, 0,0,1,0, 0));
        tbl.push_back(mk(0,0,1,0,0, 0, 0,0,1,1, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0,0,0,0,1, 0, 0,0,1,1, 0));
        tbl.push_back(mk(0,0,0,1,0, 0, 1,0,0,0, 5));
        tbl.push_back(mk(0,0,0,0,0, 0, 0,0,0,0, 5));
        // Timeout at limit 3.
        tbl.push_back(mk(1,0,0,0,0, 3, 0,0,1,0, 5));
        tbl.push_back(mk(0,0,1,0,1, 3, 0,0,1,1, 5));
        tbl.push_back(mk(0,0,0,0,1, 3, 0,0,1,1, 5));
        tbl.push_back(mk(0,0,0,0,1, 3, 0,0,1,1, 5));
        tbl.push_back(mk(0,0,0,0,1, 3, 1,1,0,0, 3));
        tbl.push_back(mk(0,0,0,0,1, 3, 0,1,0,0, 3));
        // Stop coincident with the limit-reaching tick: stop wins.
        tbl.push_back(mk(1,0,0,0,0, 3, 0,1,1,0, 3));
        tbl.push_back(mk(0,0,1,0,0, 3, 0,1,1,1, 3));
        tbl.push_back(mk(0,0,0,0,1, 3, 0,1,1,1, 3));
        tbl.push_back(mk(0,0,0,0,1, 3, 0,1,1,1, 3));
        tbl.push_back(mk(0,0,0,1,1, 3, 1,0,0,0, 3));
        // Stop without arm, stop while armed, tick coincident with start.
        tbl.push_back(mk(0,0,0,1,0, 0, 0,0,0,0, 3));
        tbl.push_back(mk(0,0,1,1,1, 0, 0,0,0,0, 3));
        tbl.push_back(mk(1,0,0,0,0, 0, 0,0,1,0, 3));
        tbl.push_back(mk(0,0,0,1,0, 0, 0,0,1,0, 3));
        tbl.push_back(mk(0,0,1,0,1, 0, 0,0,1,1, 3));
        tbl.push_back(mk(0,0,0,0,1, 0, 0,0,1,1, 3));
        tbl.push_back(mk(1,0,0,0,1, 0, 0,0,1,1, 3));
        tbl.push_back(mk(0,0,0,1,0, 0, 1,0,0,0, 2));
        // start and stop together in ARMED only starts.
        tbl.push_back(mk(1,0,0,0,0, 0, 0,0,1,0, 2));
        tbl.push_back(mk(0,0,1,1,0, 0, 0,0,1,1, 2));
        tbl.push_back(mk(0,0,0,1,1, 0, 1,0,0,0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].arm, tbl[i].abort, tbl[i].start, tbl[i].stop, tbl[i].tick, tbl[i].limit);
            cycle();
            chk($sformatf("vec%0d", i), outs(),
                {tbl[i].v, tbl[i].t, tbl[i].b, tbl[i].r, tbl[i].c});
        end

        // Abort mid-count: no result, previous count kept.
        drive(1,0,0,0,0,0); cycle();
        drive(0,0,1,0,0,0); cycle();
        drive(0,0,0,0,1,0); cycle(); cycle();
        drive(0,1,0,1,1,0); cycle();
        chk("abort", outs(), {4'b0000, 32'd1});
        drive(0,0,0,1,1,0); cycle();
        chk("abort_after", outs(), {4'b0000, 32'd1});

        // Reset while counting: immediate clear, no result after release.
        drive(1,0,0,0,0,0); cycle();
        drive(0,0,1,0,0,0); cycle();
        drive(0,0,0,0,1,0); cycle();
        rstn_i = 1'b0;
        #1;
        chk("async_reset", outs(), 36'd0);
        cycle();
        drive(0,0,0,1,1,0);
        rstn_i = 1'b1;
        cycle();
        chk("post_reset_1", outs(), 36'd0);
        cycle();
        chk("post_reset_2", outs(), 36'd0);

        // Saturation in the 4-bit instance.
        drive(1,0,0,0,0,0); cycle();
        drive(0,0,1,0,0,0); cycle();
        drive(0,0,0,0,1,0); repeat (20) cycle();
        drive(0,0,0,1,0,0); cycle();
        chk("sat_cw4", {valid4_o, timeout4_o, busy4_o, running4_o, 28'd0, count4_o},
            {4'b1000, 32'd15});
        chk("no_sat_cw32", outs(), {4'b1000, 32'd20});

        // Randomized run against the reference model.
        do_reset();
        begin
            logic [31:0] lim;
            bit a, ab, s, st, t;
            lim = 0;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 19) == 0)
                    lim = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 12));
                a  = ($urandom_range(0, 5) == 0);
                ab = ($urandom_range(0, 49) == 0);
                s  = ($urandom_range(0, 4) == 0);
                st = ($urandom_range(0, 11) == 0);
                t  = $urandom_range(0, 1) == 1;
                drive(a, ab, s, st, t, lim);
                model_step(a, ab, s, st, t, longint'(lim));
                cycle();
                chk($sformatf("rand%0d", n), outs(),
                    {m_valid, m_to, m_mode != 0, m_mode == 2, 32'(m_count)});
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/tick_interval_meter.md
Name: tick_interval_meter

Overview:
- Measures the number of timer_tick pulses between a start event and a stop event, then captures the result. It is the measuring counterpart to the countdown timer.
- Output is a captured tick count, which can be fed back as the N load value of a countdown timer.
- Sits beside the countdown timers in the FPGA timing/trigger logic. Read by register logic through a one-cycle result strobe.

Parameters:
- CW, 32, width of the tick counter, limit and result.

Ports:
- clk_i  input  1  system clock; all logic on rising edge
- rstn_i  input  1  asynchronous active-low reset
- arm_i  input  1  one-cycle pulse; enables capture of the next start event
- abort_i  input  1  one-cycle pulse; returns to IDLE, no result
- start_i  input  1  start event, level sampled each cycle
- stop_i  input  1  stop event, level sampled each cycle
- timer_tick_i  input  1  tick enable; counted only when high
- limit_i  input  CW  timeout in ticks; 0 disables timeout
- count_o  output  CW  captured tick count, held until next result
- valid_o  output  1  one-cycle pulse when count_o is updated
- timeout_o  output  1  flag for the last result: 1 = ended by limit, 0 = ended by stop
- busy_o  output  1  high in ARMED or COUNTING
- running_o  output  1  high in COUNTING only

Behaviour:
- Reset (rstn_i low, asynchronous):
  - state = IDLE; internal counter = 0
  - count_o = 0, valid_o = 0, timeout_o = 0, busy_o = 0, running_o = 0
- States: IDLE, ARMED, COUNTING. valid_o is a registered pulse and does not have its own state.
- IDLE:
  - arm_i → ARMED (next cycle).
  - start_i and stop_i are ignored.
- ARMED:
  - start_i high → COUNTING; internal counter cleared to 0.
  - A timer_tick_i in the same cycle as start_i is not counted.
  - stop_i alone is ignored.
- COUNTING, each cycle timer_tick_i is high:
  - counter += 1.
  - Counter saturates at all-ones (2^CW-1) and does not wrap.
- COUNTING, stop_i high:
  - count_o = counter value including a tick in that same cycle.
  - timeout_o = 0.
  - valid_o = 1 for exactly one cycle (the cycle after the stop is sampled).
  - → IDLE.
- COUNTING, timeout (limit_i != 0 and the incremented counter would reach limit_i on a tick):
  - count_o = limit_i, timeout_o = 1, valid_o pulse, → IDLE.
- Stop and timeout in the same cycle: stop wins, timeout_o = 0, count_o = limit_i.
- start_i and stop_i both high in ARMED: go to COUNTING only; the stop is ignored.
- Latency: count_o and valid_o are registered; both update on the clock edge following the sampled stop or limit cycle.
- Re-arm: the block is single-shot. A new arm_i is needed after each result.
  - arm_i while ARMED or COUNTING is ignored.
- Abort:
  - abort_i in any state → IDLE, no valid_o; count_o and timeout_o unchanged.
  - abort_i has priority over all other inputs.
- limit_i is sampled continuously; changing it mid-count takes effect immediately.
  - If the counter is already ≥ a newly written non-zero limit_i, timeout fires on the next tick.
- start_i and stop_i are level-sampled, not edge-detected. Callers supply single-cycle pulses or a synchronized edge.
- busy_o and running_o are decoded from the state register: no glitches, one cycle after the transition.
- Reset mid-COUNTING: all state cleared immediately; no valid_o pulse after release.

Test Plan:
- Reset then arm, start, 5 ticks, stop (stop cycle without tick) → count_o = 5, timeout_o = 0, valid_o high for 1 cycle, busy_o low afterward.
- limit_i = 3, arm, start, continuous ticks, no stop → valid_o after the 3rd tick, count_o = 3, timeout_o = 1.
- Stop coincident with the 3rd tick at limit_i = 3 → count_o = 3, timeout_o = 0.
- CW=4 build, limit_i = 0, 20 ticks then stop → count_o = 15 (saturation, no wrap).
- Stop without arm, and start with tick in the same cycle → stop ignored, no valid_o; the tick coincident with start is not counted (start + 2 further ticks + stop → count_o = 2).
- abort_i mid-COUNTING, then rstn_i pulsed mid-COUNTING after re-arm → no valid_o in either case, previous count_o retained after abort, count_o = 0 after reset.
